// File: rtl/dac_write_arbiter.sv
// dac_write_arbiter
// Shares one 16-bit SPI DAC serializer between NCH requesters using a
// round-robin grant. The module builds the frame {ch, CMD, code} and runs
// one serializer transfer at a time. It acks the requester when the
// transfer finishes, then holds an idle gap of GAP cycles before the next
// grant.
// Optional build macro: DAC_ARB_TIMEOUT_EN adds a WAIT-state watchdog.
// The watchdog aborts the frame after TIMEOUT cycles and sets the sticky
// err flag.
module dac_write_arbiter #(
    parameter int         NCH     = 4,
    parameter int         DW      = 12,
    parameter logic [1:0] CMD     = 2'b11,
    parameter int         GAP     = 8,
    parameter int         TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] code,
    output logic [NCH-1:0]    ack,
    output logic              spi_tx_en,
    output logic [15:0]       spi_data,
    input  logic              spi_tx_done,
    output logic              busy,
    output logic [1:0]        cur_ch,
    output logic              err,
    input  logic              err_clr
);

    localparam int GW = $clog2(GAP) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP} state_t;

    state_t          state_reg;
    logic [1:0]      rr_reg;
    logic            done_d_reg;
    logic [11:0]     code_reg;
    logic [GW-1:0]   gap_cnt_reg;

    logic [2*NCH-1:0] req_dbl;
    logic [NCH-1:0]   req_rot;
    logic             pick_valid;
    logic [1:0]       pick_ch;
    logic [1:0]       rr_next;
    logic [DW-1:0]    code_sel;
    logic             done_rise;
    logic [NCH-1:0]   ch_onehot;

    // Rotate the request vector so that bit 0 is the channel at the rr pointer.
    assign req_dbl = {req, req};
    assign req_rot = NCH'(req_dbl >> rr_reg);

    // Pick the first requester at or after the rr pointer, wrapping modulo NCH.
    always_comb begin
        int off;
        int sum;
        off        = 0;
        pick_valid = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_valid = 1'b1;
                off        = i;
            end
        end
        sum = int'(rr_reg) + off;
        if (sum >= NCH) begin
            sum = sum - NCH;
        end
        pick_ch = 2'(sum);
        rr_next = (pick_ch == 2'(NCH - 1)) ? 2'd0 : pick_ch + 2'd1;
    end

    assign code_sel  = code[int'(pick_ch)*DW +: DW];
    assign done_rise = spi_tx_done & ~done_d_reg;
    assign ch_onehot = {{(NCH-1){1'b0}}, 1'b1} << cur_ch;
    assign busy      = (state_reg != S_IDLE);

`ifdef DAC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] wait_cnt_reg;
`else
    wire [31:0] unused_timeout = TIMEOUT;
    wire        unused_err_clr = err_clr;
    assign err = 1'b0;
`endif

    // Grant, frame sequencing, completion detect and gap timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            rr_reg       <= 2'd0;
            done_d_reg   <= 1'b0;
            code_reg     <= 12'd0;
            gap_cnt_reg  <= '0;
            ack          <= '0;
            spi_tx_en    <= 1'b0;
            spi_data     <= 16'd0;
            cur_ch       <= 2'd0;
`ifdef DAC_ARB_TIMEOUT_EN
            wait_cnt_reg <= '0;
            err          <= 1'b0;
`endif
        end else begin
            done_d_reg <= spi_tx_done;
            ack        <= '0;
            spi_tx_en  <= 1'b0;
`ifdef DAC_ARB_TIMEOUT_EN
            // A clear is overridden by a timeout set in the same cycle (later assignment).
            if (err_clr) begin
                err <= 1'b0;
            end
`endif
            case (state_reg)
                S_IDLE: begin
                    if (pick_valid) begin
                        cur_ch    <= pick_ch;
                        rr_reg    <= rr_next;
                        code_reg  <= 12'(code_sel);
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    spi_data  <= {cur_ch, CMD, code_reg};
                    spi_tx_en <= 1'b1;
                    state_reg <= S_WAIT;
`ifdef DAC_ARB_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                S_WAIT: begin
                    // A done level already high on entry is ignored; only a fresh rise completes.
                    if (done_rise) begin
                        ack         <= ch_onehot;
                        gap_cnt_reg <= '0;
                        state_reg   <= S_GAP;
`ifdef DAC_ARB_TIMEOUT_EN
                    end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
                        err         <= 1'b1;
                        ack         <= ch_onehot;
                        gap_cnt_reg <= '0;
                        state_reg   <= S_GAP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg == GW'(GAP - 1)) begin
                        state_reg <= S_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed testbench for dac_write_arbiter (NCH=4, DW=12, GAP=8).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
// Build with DAC_ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT=16).
module tb_dac_write_arbiter;

`ifdef DAC_ARB_TIMEOUT_EN
    localparam int TOUT = 16;
`else
    localparam int TOUT = 1024;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [47:0] code;
    logic [3:0]  ack;
    logic        spi_tx_en;
    logic [15:0] spi_data;
    logic        spi_tx_done;
    logic        busy;
    logic [1:0]  cur_ch;
    logic        err;
    logic        err_clr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    dac_write_arbiter #(
        .NCH(4), .DW(12), .CMD(2'b11), .GAP(8), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .code(code), .ack(ack),
        .spi_tx_en(spi_tx_en), .spi_data(spi_data), .spi_tx_done(spi_tx_done),
        .busy(busy), .cur_ch(cur_ch), .err(err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_tx(input string tag, output int n);
        n = 0;
        while (spi_tx_en !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk(tag, 32'(spi_tx_en), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Serializer model: one cycle after the start pulse, raise done, expect the ack, and then drop done.
    task automatic finish_frame(input string tag, input logic [3:0] exp_ack, input logic drop);
        tick();
        chk({tag, "_txen_pulse"}, 32'(spi_tx_en), 32'd0);
        spi_tx_done = 1'b1;
        tick();
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        spi_tx_done = 1'b0;
        if (drop) req = req & ~exp_ack;
        tick();
        chk({tag, "_ack_clear"}, 32'(ack), 32'd0);
    endtask

    initial begin
        int n;
        int last_cyc;
        logic [3:0]  acc;
        logic [15:0] exp_data [5];
        logic [3:0]  exp_ack  [5];
        logic [1:0]  exp_ch   [5];

        exp_data = '{16'h3100, 16'h7101, 16'hB102, 16'hF103, 16'h3100};
        exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_ch   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b0; req = 4'b0; code = 48'h0; spi_tx_done = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_tx_en", 32'(spi_tx_en), 32'd0);
        chk("rst_data", 32'(spi_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_ch", 32'(cur_ch), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        // Test 1: a single request on ch2.
        code[24 +: 12] = 12'hA5C;
        req = 4'b0100;
        wait_tx("t1_tx_en", n);
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_data", 32'(spi_data), 32'hBA5C);
        chk("t1_cur_ch", 32'(cur_ch), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        finish_frame("t1", 4'b0100, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("t1_busy_in_gap", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_after_gap", 32'(busy), 32'd0);

        // Test 2: all four requests held, so grants rotate 0,1,2,3,0.
        do_reset();
        code = {12'h103, 12'h102, 12'h101, 12'h100};
        req = 4'b1111;
        last_cyc = cyc;
        for (int i = 0; i < 5; i++) begin
            wait_tx("t2_tx_en", n);
            if (i > 0) chk("t2_spacing_ok", 32'((cyc - last_cyc) >= 11), 32'd1);
            last_cyc = cyc;
            chk("t2_cur_ch", 32'(cur_ch), 32'(exp_ch[i]));
            chk("t2_data", 32'(spi_data), 32'(exp_data[i]));
            finish_frame("t2", exp_ack[i], 1'b0);
        end
        req = 4'b0;

        // Test 3: the code is captured at grant, so a change during WAIT waits for the next frame.
        do_reset();
        code[12 +: 12] = 12'h111;
        req = 4'b0010;
        wait_tx("t3_tx_en", n);
        chk("t3_data", 32'(spi_data), 32'h7111);
        tick();
        code[12 +: 12] = 12'h222;
        tick();
        tick();
        chk("t3_data_held", 32'(spi_data), 32'h7111);
        finish_frame("t3", 4'b0010, 1'b1);
        req = 4'b0010;
        wait_tx("t3_tx_en2", n);
        chk("t3_data_new", 32'(spi_data), 32'h7222);
        finish_frame("t3b", 4'b0010, 1'b1);

        // Test 4: done is stuck high before the grant, so the transfer needs a fresh rise.
        do_reset();
        spi_tx_done = 1'b1;
        tick();
        tick();
        code[36 +: 12] = 12'h0F0;
        req = 4'b1000;
        wait_tx("t4_tx_en", n);
        chk("t4_data", 32'(spi_data), 32'hF0F0);
        acc = 4'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc = acc | ack;
        end
        chk("t4_no_ack_stuck", 32'(acc), 32'd0);
        spi_tx_done = 1'b0;
        tick();
        chk("t4_no_ack_fall", 32'(ack), 32'd0);
        spi_tx_done = 1'b1;
        tick();
        chk("t4_ack", 32'(ack), 32'b1000);
        req = 4'b0;
        spi_tx_done = 1'b0;
        tick();
        chk("t4_ack_clear", 32'(ack), 32'd0);

        // Test 5: an asynchronous reset in mid-WAIT, after which arbitration restarts from rr=0.
        do_reset();
        code[24 +: 12] = 12'h5A5;
        req = 4'b0100;
        wait_tx("t5_tx_en", n);
        tick();
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tx_en", 32'(spi_tx_en), 32'd0);
        chk("t5_data", 32'(spi_data), 32'd0);
        chk("t5_cur_ch", 32'(cur_ch), 32'd0);
        chk("t5_ack", 32'(ack), 32'd0);
        req = 4'b1111;
        tick();
        rst = 1'b1;
        wait_tx("t5_tx_en2", n);
        chk("t5_rr_restart", 32'(cur_ch), 32'd0);
        finish_frame("t5", 4'b0001, 1'b1);
        req = 4'b0;

`ifdef DAC_ARB_TIMEOUT_EN
        // Test 6: the watchdog fires 16 cycles after the start pulse, and err_clr clears err.
        do_reset();
        code[0 +: 12] = 12'h123;
        req = 4'b0001;
        wait_tx("t6_tx_en", n);
        for (int i = 0; i < 15; i++) tick();
        chk("t6_err_early", 32'(err), 32'd0);
        chk("t6_ack_early", 32'(ack), 32'd0);
        tick();
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_ack", 32'(ack), 32'b0001);
        req = 4'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t6_err_clr", 32'(err), 32'd0);
        chk("t6_ack_clear", 32'(ack), 32'd0);
`else
        chk("t6_err_tied", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
